// File: rtl/eth_pkg.sv
// Shared types and constants for the GMII Ethernet transmit MAC.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DRAIN,
    IFG
  } tx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam int          ETH_MIN_FRAME = 60;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_mac_tx_if.sv
// Byte-stream input and GMII output bundle of the transmit MAC.
// Handshake: a byte moves on a rising edge where s_tvalid && s_tready; s_tvalid may rise
// without waiting for s_tready, and s_tready never depends combinationally on s_tvalid.
interface eth_mac_tx_if;
  import eth_pkg::*;

  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic [7:0] gmii_txd;
  logic       tx_busy;
  logic       tx_underrun;
  tx_state_e  dbg_state;

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready, gmii_tx_en, gmii_tx_er, gmii_txd, tx_busy, tx_underrun, dbg_state
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready, gmii_tx_en, gmii_tx_er, gmii_txd, tx_busy, tx_underrun, dbg_state
  );
endinterface

// File: rtl/eth_mac_tx_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32; purely combinational.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_mac_tx.sv
// GMII transmit MAC: preamble/SFD, payload, zero padding, CRC-32 FCS, inter-frame gap.
// Each state computes the byte shown on GMII in the following cycle.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int PAD_EN     = 1,
  parameter int IFG_CYCLES = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        reset,
  eth_mac_tx_if.slave bus
);

  localparam logic [5:0] MIN_FRAME_B = 6'(ETH_MIN_FRAME);
  localparam logic [7:0] IFG_LAST    = 8'(IFG_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [7:0]  txd_q, txd_d;
  logic        underrun_q, underrun_d;

  logic [5:0]  byte_cnt_inc;
  logic [7:0]  crc_byte;
  logic [31:0] crc_next;
  logic [31:0] crc_fcs;

  assign byte_cnt_inc = (byte_cnt_q == MIN_FRAME_B) ? byte_cnt_q : byte_cnt_q + 6'd1;
  assign crc_byte     = (state_q == PAD) ? 8'h00 : bus.s_tdata;
  assign crc_fcs      = ~crc_q;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    tx_en_d    = 1'b0;
    tx_er_d    = 1'b0;
    txd_d      = 8'h00;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d      = 8'd0;
        byte_cnt_d = 6'd0;
        crc_d      = CRC32_INIT;
        if (bus.s_tvalid) begin
          state_d = PREAMBLE;
          tx_en_d = 1'b1;
          txd_d   = ETH_PREAMBLE;
        end
      end
      PREAMBLE: begin
        // First preamble byte was already launched from IDLE; six more follow.
        tx_en_d = 1'b1;
        txd_d   = ETH_PREAMBLE;
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd5) begin
          state_d = SFD;
          cnt_d   = 8'd0;
        end
      end
      SFD: begin
        tx_en_d = 1'b1;
        txd_d   = ETH_SFD;
        state_d = DATA;
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (bus.s_tvalid) begin
          txd_d      = bus.s_tdata;
          crc_d      = crc_next;
          byte_cnt_d = byte_cnt_inc;
          if (bus.s_tlast) begin
            state_d = ((PAD_EN != 0) && (byte_cnt_inc < MIN_FRAME_B)) ? PAD : FCS;
          end
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = DRAIN;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_next;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc == MIN_FRAME_B) state_d = FCS;
      end
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = crc_fcs[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d   = cnt_q + 8'd1;
        if (cnt_q == 8'd3) begin
          state_d = IFG;
          cnt_d   = 8'd0;
        end
      end
      DRAIN: begin
        if (bus.s_tvalid && bus.s_tlast) begin
          state_d = IFG;
          cnt_d   = 8'd0;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      byte_cnt_q <= 6'd0;
      crc_q      <= CRC32_INIT;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      txd_q      <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      tx_er_q    <= tx_er_d;
      txd_q      <= txd_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.s_tready    = (state_q == DATA) || (state_q == DRAIN);
  assign bus.tx_busy     = (state_q != IDLE);
  assign bus.gmii_tx_en  = tx_en_q;
  assign bus.gmii_tx_er  = tx_er_q;
  assign bus.gmii_txd    = txd_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.dbg_state   = state_q;

endmodule
